// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue sequencer: opcodes, states, flag layout.
// Imported by alu_issue and alu_issue_decode.
package alu_pkg;

    localparam logic [7:0] OP_ADD_L = 8'h88;
    localparam logic [7:0] OP_ADD_M = 8'h89;
    localparam logic [7:0] OP_SUB_L = 8'h8C;
    localparam logic [7:0] OP_MUL_L = 8'h90;
    localparam logic [7:0] OP_MUL_M = 8'h91;
    localparam logic [7:0] OP_SETC  = 8'h04;
    localparam logic [7:0] OP_CLRC  = 8'h05;
    localparam logic [7:0] OP_INC   = 8'h02;
    localparam logic [7:0] OP_SETB  = 8'h60;
    localparam logic [7:0] OP_CLRB  = 8'h68;

    // Legal opcode ranges
    localparam logic [7:0] OP2_LO = 8'h88;
    localparam logic [7:0] OP2_HI = 8'h9F;
    localparam logic [7:0] OP1_LO = 8'h01;
    localparam logic [7:0] OP1_HI = 8'h0A;
    localparam logic [7:0] BIT_HI = 8'h6F;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE
    } state_t;

    // flags = {carry, zero, sign}
    localparam int FLAG_C = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_S = 0;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational opcode decoder.
// Ports: op in; legal, uses_literal, writes_w, writes_h out.
module alu_issue_decode
    import alu_pkg::*;
(
    input  logic [7:0] op,
    output logic       legal,
    output logic       uses_literal,
    output logic       writes_w,
    output logic       writes_h
);

    always_comb begin
        legal = ((op >= OP2_LO) && (op <= OP2_HI))
             || ((op >= OP1_LO) && (op <= OP1_HI))
             || ((op >= OP_SETB) && (op <= BIT_HI));
        // Even two-operand opcodes are the L-form variants
        uses_literal = op[7] & ~op[0];
        writes_w = legal && (op != OP_SETC) && (op != OP_CLRC);
        writes_h = (op == OP_MUL_L) || (op == OP_MUL_M);
    end

endmodule

// File: rtl/alu_issue.sv
// Sequencer that issues one instruction to the registered ALU and writes back W/H/flags.
// Ports: valid/ready instruction input, rf write port, alu_* drive/return, w_reg/h_reg/flags/done/err.
module alu_issue
    import alu_pkg::*;
#(
    parameter int NREGS = 8,
    parameter int DW    = 8,
    localparam int IW   = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [7:0]    instr_op,
    input  logic [DW-1:0] instr_lit,
    input  logic [IW-1:0] instr_reg,
    input  logic          rf_wr_en,
    input  logic [IW-1:0] rf_wr_addr,
    input  logic [DW-1:0] rf_wr_data,
    output logic          alu_enable,
    output logic [7:0]    alu_operation,
    output logic [DW-1:0] alu_op1,
    output logic [DW-1:0] alu_op2,
    output logic          alu_cpu_carry,
    input  logic [DW-1:0] alu_result_l,
    input  logic [DW-1:0] alu_result_h,
    input  logic          alu_carry,
    input  logic          alu_zero,
    input  logic          alu_sign,
    output logic [DW-1:0] w_reg,
    output logic [DW-1:0] h_reg,
    output logic [2:0]    flags,
    output logic          done,
    output logic          err
);

    state_t        state;
    logic [DW-1:0] rf [NREGS];
    logic          dec_legal;
    logic          dec_lit;
    logic          dec_w;
    logic          dec_h;
    logic          wb_w;
    logic          wb_h;
    logic          accept;

    assign instr_ready = (state == IDLE);
    assign accept      = instr_valid && instr_ready;

    alu_issue_decode u_dec (
        .op           (instr_op),
        .legal        (dec_legal),
        .uses_literal (dec_lit),
        .writes_w     (dec_w),
        .writes_h     (dec_h)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            rf            <= '{default: '0};
            w_reg         <= '0;
            h_reg         <= '0;
            flags         <= '0;
            done          <= 1'b0;
            err           <= 1'b0;
            alu_enable    <= 1'b0;
            alu_operation <= '0;
            alu_op1       <= '0;
            alu_op2       <= '0;
            alu_cpu_carry <= 1'b0;
            wb_w          <= 1'b0;
            wb_h          <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            // Operand read below sees the pre-write value at the same edge
            if (rf_wr_en) rf[rf_wr_addr] <= rf_wr_data;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        if (dec_legal) begin
                            state         <= ISSUE;
                            alu_enable    <= 1'b1;
                            alu_operation <= instr_op;
                            alu_op1       <= w_reg;
                            alu_op2       <= dec_lit ? instr_lit
                                                     : rf[instr_reg];
                            alu_cpu_carry <= flags[FLAG_C];
                            wb_w          <= dec_w;
                            wb_h          <= dec_h;
                        end else begin
                            done <= 1'b1;
                            err  <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    state         <= CAPTURE;
                    alu_enable    <= 1'b0;
                    alu_operation <= '0;
                    alu_op1       <= '0;
                    alu_op2       <= '0;
                    alu_cpu_carry <= 1'b0;
                end
                CAPTURE: begin
                    if (wb_w) w_reg <= alu_result_l;
                    if (wb_h) h_reg <= alu_result_h;
                    flags <= {alu_carry, alu_zero, alu_sign};
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue with a behavioural ALU stand-in.
// Directed table, back-to-back sequence, random instructions, reset mid-issue.
module tb_alu_issue;

    logic       clk = 1'b0;
    logic       rst;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] instr_op;
    logic [7:0] instr_lit;
    logic [2:0] instr_reg;
    logic       rf_wr_en;
    logic [2:0] rf_wr_addr;
    logic [7:0] rf_wr_data;
    logic       alu_enable;
    logic [7:0] alu_operation;
    logic [7:0] alu_op1;
    logic [7:0] alu_op2;
    logic       alu_cpu_carry;
    logic [7:0] alu_result_l = '0;
    logic [7:0] alu_result_h = '0;
    logic       alu_carry = 1'b0;
    logic       alu_zero = 1'b0;
    logic       alu_sign = 1'b0;
    logic [7:0] w_reg;
    logic [7:0] h_reg;
    logic [2:0] flags;
    logic       done;
    logic       err;

    always #5 clk = ~clk;

    alu_issue dut (
        .clk           (clk),
        .rst           (rst),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_op      (instr_op),
        .instr_lit     (instr_lit),
        .instr_reg     (instr_reg),
        .rf_wr_en      (rf_wr_en),
        .rf_wr_addr    (rf_wr_addr),
        .rf_wr_data    (rf_wr_data),
        .alu_enable    (alu_enable),
        .alu_operation (alu_operation),
        .alu_op1       (alu_op1),
        .alu_op2       (alu_op2),
        .alu_cpu_carry (alu_cpu_carry),
        .alu_result_l  (alu_result_l),
        .alu_result_h  (alu_result_h),
        .alu_carry     (alu_carry),
        .alu_zero      (alu_zero),
        .alu_sign      (alu_sign),
        .w_reg         (w_reg),
        .h_reg         (h_reg),
        .flags         (flags),
        .done          (done),
        .err           (err)
    );

    typedef struct packed {
        logic [7:0] l;
        logic [7:0] h;
        logic       c;
    } alu_out_t;

    function automatic alu_out_t alu_fn(logic [7:0] op, logic [7:0] a,
                                        logic [7:0] b, logic cin);
        alu_out_t   r;
        logic [8:0] s;
        logic [15:0] p;
        r   = '0;
        r.l = a;
        if (op == 8'h88 || op == 8'h89) begin
            s = {1'b0, a} + {1'b0, b};
            r.l = s[7:0];
            r.c = s[8];
        end else if (op == 8'h8A || op == 8'h8B) begin
            s = {1'b0, a} + {1'b0, b} + {8'h00, cin};
            r.l = s[7:0];
            r.c = s[8];
        end else if (op == 8'h8C || op == 8'h8D) begin
            r.l = a - b;
            r.c = (a < b);
        end else if (op == 8'h90 || op == 8'h91) begin
            p = {8'h00, a} * {8'h00, b};
            r.l = p[7:0];
            r.h = p[15:8];
        end else if (op == 8'h04) begin
            r.c = 1'b1;
        end else if (op == 8'h02) begin
            r.l = a + 8'h01;
            r.c = (a == 8'hFF);
        end else if (op >= 8'h60 && op <= 8'h67) begin
            r.l = a | (8'h01 << op[2:0]);
        end else if (op >= 8'h68 && op <= 8'h6F) begin
            r.l = a & ~(8'h01 << op[2:0]);
        end
        return r;
    endfunction

    // Registered ALU stand-in: result valid the cycle after the enable
    alu_out_t ao;
    assign ao = alu_fn(alu_operation, alu_op1, alu_op2, alu_cpu_carry);
    always @(posedge clk) begin
        if (alu_enable) begin
            alu_result_l <= ao.l;
            alu_result_h <= ao.h;
            alu_carry    <= ao.c;
            alu_zero     <= (ao.l == 8'h00);
            alu_sign     <= ao.l[7];
        end
    end

    // Architectural reference model
    logic [7:0] m_w;
    logic [7:0] m_h;
    logic [2:0] m_f;
    logic [7:0] m_rf [8];

    int checks   = 0;
    int failures = 0;

    function automatic bit is_legal(logic [7:0] op);
        return op inside {[8'h88:8'h9F], [8'h01:8'h0A], [8'h60:8'h6F]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_w = '0;
        m_h = '0;
        m_f = '0;
        for (int i = 0; i < 8; i++) m_rf[i] = '0;
    endtask

    // Expected operands from architectural state, then retire into the model
    task automatic model_issue(input logic [7:0] op, input logic [7:0] lit,
                               input logic [2:0] r, output logic [7:0] o1,
                               output logic [7:0] o2, output logic oc);
        alu_out_t res;
        o1 = m_w;
        o2 = (op[7] && !op[0]) ? lit : m_rf[r];
        oc = m_f[2];
        if (is_legal(op)) begin
            res = alu_fn(op, o1, o2, oc);
            if (op != 8'h04 && op != 8'h05) m_w = res.l;
            if (op == 8'h90 || op == 8'h91) m_h = res.h;
            m_f = {res.c, res.l == 8'h00, res.l[7]};
        end
    endtask

    task automatic rf_write(input logic [2:0] a, input logic [7:0] d);
        rf_wr_en   = 1'b1;
        rf_wr_addr = a;
        rf_wr_data = d;
        @(negedge clk);
        rf_wr_en = 1'b0;
        m_rf[a] = d;
    endtask

    // Called just after a negedge with the DUT idle; returns in the done cycle
    task automatic run_instr(input logic [7:0] op, input logic [7:0] lit,
                             input logic [2:0] r, input logic we,
                             input logic [2:0] wa, input logic [7:0] wd);
        logic [7:0] e1;
        logic [7:0] e2;
        logic       ec;
        chk($sformatf("ready op%02h", op), instr_ready, 1);
        model_issue(op, lit, r, e1, e2, ec);
        if (we) m_rf[wa] = wd;
        instr_valid = 1'b1;
        instr_op    = op;
        instr_lit   = lit;
        instr_reg   = r;
        rf_wr_en    = we;
        rf_wr_addr  = wa;
        rf_wr_data  = wd;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        rf_wr_en    = 1'b0;
        if (is_legal(op)) begin
            chk($sformatf("enable op%02h", op), alu_enable, 1);
            chk($sformatf("operation op%02h", op), alu_operation, op);
            chk($sformatf("op1 op%02h", op), alu_op1, e1);
            chk($sformatf("op2 op%02h", op), alu_op2, e2);
            chk($sformatf("cpu_carry op%02h", op), alu_cpu_carry, ec);
            chk($sformatf("early_done op%02h", op), done, 0);
            @(negedge clk);
            chk($sformatf("enable_drop op%02h", op), alu_enable, 0);
            chk($sformatf("ops_zero op%02h", op),
                {alu_operation, alu_op1, alu_op2}, 0);
            chk($sformatf("capture_done op%02h", op), done, 0);
            @(negedge clk);
            chk($sformatf("done op%02h", op), done, 1);
            chk($sformatf("err op%02h", op), err, 0);
        end else begin
            chk($sformatf("illegal_en op%02h", op), alu_enable, 0);
            chk($sformatf("illegal_done op%02h", op), done, 1);
            chk($sformatf("illegal_err op%02h", op), err, 1);
            chk($sformatf("illegal_ready op%02h", op), instr_ready, 1);
        end
        chk($sformatf("w_reg op%02h", op), w_reg, m_w);
        chk($sformatf("h_reg op%02h", op), h_reg, m_h);
        chk($sformatf("flags op%02h", op), flags, m_f);
    endtask

    typedef struct {
        logic [7:0] op;
        logic [7:0] lit;
        logic [2:0] r;
        logic [7:0] ew;
        logic [7:0] eh;
        logic [2:0] ef;
        logic       ee;
    } vec_t;

    vec_t tbl[$];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] pool [12];
        int         acc_c[$];
        int         n_acc;
        int         n_done;
        bit         pend;
        logic [7:0] pend_op2;
        logic [7:0] o1;
        logic [7:0] o2;
        logic       oc;
        logic [7:0] op;

        rst         = 1'b0;
        instr_valid = 1'b0;
        instr_op    = '0;
        instr_lit   = '0;
        instr_reg   = '0;
        rf_wr_en    = 1'b0;
        rf_wr_addr  = '0;
        rf_wr_data  = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_enable", alu_enable, 0);
        chk("reset_regs", {w_reg, h_reg, flags}, 0);
        chk("reset_done_err", {done, err}, 0);
        chk("reset_alu_out", {alu_operation, alu_op1, alu_op2, alu_cpu_carry}, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", instr_ready, 1);

        rf_write(3'd3, 8'h20);

        tbl.push_back('{8'h88, 8'h10, 3'd0, 8'h10, 8'h00, 3'b000, 1'b0});
        tbl.push_back('{8'h88, 8'h05, 3'd0, 8'h15, 8'h00, 3'b000, 1'b0});
        tbl.push_back('{8'h8C, 8'h11, 3'd0, 8'h04, 8'h00, 3'b000, 1'b0});
        tbl.push_back('{8'h91, 8'h00, 3'd3, 8'h80, 8'h00, 3'b001, 1'b0});
        tbl.push_back('{8'h8C, 8'h2B, 3'd0, 8'h55, 8'h00, 3'b000, 1'b0});
        tbl.push_back('{8'h04, 8'h00, 3'd0, 8'h55, 8'h00, 3'b100, 1'b0});
        tbl.push_back('{8'h89, 8'h00, 3'd0, 8'h55, 8'h00, 3'b000, 1'b0});
        tbl.push_back('{8'h7F, 8'h00, 3'd0, 8'h55, 8'h00, 3'b000, 1'b1});
        tbl.push_back('{8'h90, 8'h10, 3'd0, 8'h50, 8'h05, 3'b000, 1'b0});
        tbl.push_back('{8'h04, 8'h00, 3'd0, 8'h50, 8'h05, 3'b100, 1'b0});
        tbl.push_back('{8'h8A, 8'h01, 3'd0, 8'h52, 8'h05, 3'b000, 1'b0});
        tbl.push_back('{8'h05, 8'h00, 3'd0, 8'h52, 8'h05, 3'b000, 1'b0});
        tbl.push_back('{8'h00, 8'h00, 3'd0, 8'h52, 8'h05, 3'b000, 1'b1});
        tbl.push_back('{8'h0B, 8'h00, 3'd0, 8'h52, 8'h05, 3'b000, 1'b1});
        tbl.push_back('{8'h87, 8'h00, 3'd0, 8'h52, 8'h05, 3'b000, 1'b1});
        tbl.push_back('{8'hA0, 8'h00, 3'd0, 8'h52, 8'h05, 3'b000, 1'b1});
        tbl.push_back('{8'h5F, 8'h00, 3'd0, 8'h52, 8'h05, 3'b000, 1'b1});
        tbl.push_back('{8'h70, 8'h00, 3'd0, 8'h52, 8'h05, 3'b000, 1'b1});
        tbl.push_back('{8'h01, 8'h00, 3'd0, 8'h52, 8'h05, 3'b000, 1'b0});
        tbl.push_back('{8'h0A, 8'h00, 3'd0, 8'h52, 8'h05, 3'b000, 1'b0});
        tbl.push_back('{8'h9F, 8'h00, 3'd0, 8'h52, 8'h05, 3'b000, 1'b0});
        tbl.push_back('{8'h60, 8'h00, 3'd0, 8'h53, 8'h05, 3'b000, 1'b0});
        tbl.push_back('{8'h6F, 8'h00, 3'd0, 8'h53, 8'h05, 3'b000, 1'b0});
        tbl.push_back('{8'h02, 8'h00, 3'd0, 8'h54, 8'h05, 3'b000, 1'b0});
        tbl.push_back('{8'h8C, 8'h54, 3'd0, 8'h00, 8'h05, 3'b010, 1'b0});
        tbl.push_back('{8'h02, 8'h00, 3'd0, 8'h01, 8'h05, 3'b000, 1'b0});
        tbl.push_back('{8'hFF, 8'h00, 3'd0, 8'h01, 8'h05, 3'b000, 1'b1});

        foreach (tbl[i]) begin
            run_instr(tbl[i].op, tbl[i].lit, tbl[i].r, 1'b0, 3'd0, 8'h00);
            chk($sformatf("tbl%0d w_reg", i), w_reg, tbl[i].ew);
            chk($sformatf("tbl%0d h_reg", i), h_reg, tbl[i].eh);
            chk($sformatf("tbl%0d flags", i), flags, tbl[i].ef);
            chk($sformatf("tbl%0d err", i), err, tbl[i].ee);
        end

        // Back-to-back ADD M-form with valid held; rf[2] rewritten at 2nd accept
        rf_write(3'd2, 8'h07);
        n_acc  = 0;
        n_done = 0;
        pend   = 1'b0;
        pend_op2 = '0;
        instr_valid = 1'b1;
        instr_op    = 8'h89;
        instr_lit   = 8'h00;
        instr_reg   = 3'd2;
        for (int c = 0; c < 40; c++) begin
            if (c > 0) @(negedge clk);
            rf_wr_en = 1'b0;
            if (pend) begin
                chk("b2b_enable", alu_enable, 1);
                chk("b2b_op2", alu_op2, pend_op2);
                pend = 1'b0;
            end
            if (done) n_done++;
            if (n_done == 3) break;
            if (instr_ready && n_acc < 3) begin
                acc_c.push_back(c);
                model_issue(8'h89, 8'h00, 3'd2, o1, o2, oc);
                pend_op2 = o2;
                pend = 1'b1;
                if (n_acc == 1) begin
                    rf_wr_en   = 1'b1;
                    rf_wr_addr = 3'd2;
                    rf_wr_data = 8'h30;
                    m_rf[2]    = 8'h30;
                end
                n_acc++;
            end else if (n_acc == 3) begin
                instr_valid = 1'b0;
            end
        end
        instr_valid = 1'b0;
        chk("b2b_done_count", n_done, 3);
        chk("b2b_accept_count", n_acc, 3);
        if (acc_c.size() == 3) begin
            chk("b2b_gap1", acc_c[1] - acc_c[0], 3);
            chk("b2b_gap2", acc_c[2] - acc_c[1], 3);
        end
        chk("b2b_w_reg", w_reg, m_w);
        chk("b2b_w_value", w_reg, 8'h3F);

        // Random instructions against the model
        pool = '{8'h88, 8'h89, 8'h8A, 8'h8B, 8'h8C, 8'h8D,
                 8'h90, 8'h91, 8'h04, 8'h05, 8'h02, 8'h63};
        for (int k = 0; k < 80; k++) begin
            if ($urandom_range(0, 3) == 0) op = 8'($urandom);
            else op = pool[$urandom_range(0, 11)];
            run_instr(op, 8'($urandom), 3'($urandom_range(0, 7)),
                      1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                      8'($urandom));
        end

        // Reset while alu_enable is high
        run_instr(8'h88, 8'h42 - m_w, 3'd0, 1'b0, 3'd0, 8'h00);
        run_instr(8'h04, 8'h00, 3'd0, 1'b0, 3'd0, 8'h00);
        chk("pre_reset_w", w_reg, 8'h42);
        instr_valid = 1'b1;
        instr_op    = 8'h90;
        instr_lit   = 8'h03;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        chk("midissue_enable", alu_enable, 1);
        #2 rst = 1'b0;
        #1;
        chk("midreset_enable", alu_enable, 0);
        chk("midreset_w", w_reg, 0);
        chk("midreset_h", h_reg, 0);
        chk("midreset_flags", flags, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_reset_ready", instr_ready, 1);
        chk("post_reset_done", done, 0);
        @(negedge clk);
        chk("post_reset_no_wb", w_reg, 0);
        run_instr(8'h89, 8'h00, 3'd3, 1'b0, 3'd0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
